// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB slice.
//   ld_type_e  : m_ldType encodings (110/111 are not loads)
//   wb_state_e : writeback stage FSM states
//   is_load()  : true for the five real load encodings
package mips_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LBU  = 3'b010,
        LD_LH   = 3'b011,
        LD_LHU  = 3'b100,
        LD_LW   = 3'b101
    } ld_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE
    } wb_state_e;

    function automatic logic is_load(input logic [2:0] t);
        return (t >= LD_LB) && (t <= LD_LW);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle.
//   m_valid    : MEM result valid            (master -> slave)
//   m_ready    : WB stage can accept         (slave  -> master)
//   m_regWrite : instruction writes a reg    (master -> slave)
//   m_wa       : destination register        (master -> slave)
//   m_alu      : ALU result or load address  (master -> slave)
//   m_ldType   : load kind, see mips_pkg     (master -> slave)
interface wb_stage_if;
    logic        m_valid;
    logic        m_ready;
    logic        m_regWrite;
    logic [4:0]  m_wa;
    logic [31:0] m_alu;
    logic [2:0]  m_ldType;

    modport master (
        output m_valid, m_regWrite, m_wa, m_alu, m_ldType,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_regWrite, m_wa, m_alu, m_ldType,
        output m_ready
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load data extraction, little-endian.
//   ldType     in  3  load kind
//   addr       in  2  low address bits selecting byte/half lane
//   rdata      in  32 raw memory word
//   data       out 32 extracted, sign/zero-extended value
//   misaligned out 1  LH/LHU on odd address or LW not word aligned
module load_align
    import mips_pkg::*;
(
    input  logic [2:0]  ldType,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (ldType)
            LD_LB:   data = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data = {24'h0, byte_v};
            LD_LH: begin
                data       = {{16{half_v[15]}}, half_v};
                misaligned = addr[0];
            end
            LD_LHU: begin
                data       = {16'h0, half_v};
                misaligned = addr[0];
            end
            LD_LW: begin
                data       = rdata;
                misaligned = (addr != 2'b00);
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts MEM results, waits for load data, drives the
// register-file write port for exactly one cycle per instruction.
//   clk, rst            : clock, synchronous active-high reset
//   m (slave)           : MEM handshake bundle
//   dm_rvalid, dm_rdata : data-memory read response
//   flush               : kill a pending load
//   writeReg, wa, wd    : regfile write port (registered)
//   adel                : load address-error pulse (registered)
//   ld_pending, ld_wa   : pending load and its dest reg for hazard unit
module wb_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   m,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    input  logic        flush,
    output logic        writeReg,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        adel,
    output logic        ld_pending,
    output logic [4:0]  ld_wa
);

    wb_state_e   state_q, state_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wacap_q, wacap_d;
    logic [1:0]  addr_q, addr_d;
    logic [2:0]  ldtype_q, ldtype_d;

    logic        writeReg_q, writeReg_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic        adel_q, adel_d;
    logic        ldpend_q, ldpend_d;
    logic [4:0]  ldwa_q, ldwa_d;

    logic        accept;
    logic        in_wait;
    logic [2:0]  la_type;
    logic [1:0]  la_addr;
    logic [31:0] la_data;
    logic        la_misaligned;

    assign in_wait   = (state_q == S_WAIT);
    assign m.m_ready = ~in_wait & ~flush;
    assign accept    = m.m_valid & m.m_ready;

    // One aligner serves both uses: accept never happens in WAIT, so outside
    // WAIT it checks the incoming address, inside WAIT it extracts data.
    assign la_type = in_wait ? ldtype_q : m.m_ldType;
    assign la_addr = in_wait ? addr_q   : m.m_alu[1:0];

    load_align u_align (
        .ldType     (la_type),
        .addr       (la_addr),
        .rdata      (dm_rdata),
        .data       (la_data),
        .misaligned (la_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        regwrite_d = regwrite_q;
        wacap_d    = wacap_q;
        addr_d     = addr_q;
        ldtype_d   = ldtype_q;
        writeReg_d = 1'b0;
        wa_d       = '0;
        wd_d       = '0;
        adel_d     = 1'b0;
        ldpend_d   = 1'b0;
        ldwa_d     = '0;

        case (state_q)
            S_IDLE, S_WRITE: begin
                state_d = S_IDLE;
                if (accept) begin
                    regwrite_d = m.m_regWrite;
                    wacap_d    = m.m_wa;
                    addr_d     = m.m_alu[1:0];
                    ldtype_d   = m.m_ldType;
                    if (is_load(m.m_ldType)) begin
                        if (la_misaligned) begin
                            state_d = S_WRITE;
                            adel_d  = 1'b1;
                        end else begin
                            state_d  = S_WAIT;
                            ldpend_d = 1'b1;
                            ldwa_d   = m.m_wa;
                        end
                    end else begin
                        state_d = S_WRITE;
                        if (m.m_regWrite && (m.m_wa != '0)) begin
                            writeReg_d = 1'b1;
                            wa_d       = m.m_wa;
                            wd_d       = m.m_alu;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (dm_rvalid) begin
                    state_d = S_WRITE;
                    if (regwrite_q && (wacap_q != '0)) begin
                        writeReg_d = 1'b1;
                        wa_d       = wacap_q;
                        wd_d       = la_data;
                    end
                end else begin
                    ldpend_d = 1'b1;
                    ldwa_d   = wacap_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            regwrite_q <= 1'b0;
            wacap_q    <= '0;
            addr_q     <= '0;
            ldtype_q   <= '0;
            writeReg_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            adel_q     <= 1'b0;
            ldpend_q   <= 1'b0;
            ldwa_q     <= '0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            wacap_q    <= wacap_d;
            addr_q     <= addr_d;
            ldtype_q   <= ldtype_d;
            writeReg_q <= writeReg_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            adel_q     <= adel_d;
            ldpend_q   <= ldpend_d;
            ldwa_q     <= ldwa_d;
        end
    end

    assign writeReg   = writeReg_q;
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign adel       = adel_q;
    assign ld_pending = ldpend_q;
    assign ld_wa      = ldwa_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on posedge; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: m_valid in 1 MEM result valid; m_ready out 1 stage can accept; m_regWrite in 1 instr writes a reg; m_wa in 5 dest reg; m_alu in 32 ALU result or load address; m_ldType in 3 load kind.
REQ-003 SHALL have ports: dm_rvalid in 1 data-memory read data valid; dm_rdata in 32 read word; flush in 1 kill pending load.
REQ-004 SHALL have ports: writeReg out 1 regfile write enable; wa out 5 regfile write addr; wd out 32 regfile write data; adel out 1 load address-error pulse.
REQ-005 SHALL have ports: ld_pending out 1 load awaiting data; ld_wa out 5 its dest reg (for hazard unit).
REQ-006 m_ldType encoding SHALL be: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 treated as none.

Function
REQ-007 FSM states SHALL be IDLE, WAIT, WRITE.
REQ-008 m_ready SHALL be 1 in IDLE and WRITE, 0 in WAIT, and 0 whenever flush=1.
REQ-009 Accept = m_valid & m_ready; on accept, m_regWrite, m_wa, m_alu, m_ldType SHALL be captured.
REQ-010 Accepted non-load -> WRITE next cycle; wd = captured m_alu.
REQ-011 Accepted load -> WAIT; ld_pending=1, ld_wa=captured m_wa while in WAIT.
REQ-012 In WAIT, dm_rvalid=1 -> WRITE next cycle with wd = extracted data; dm_rvalid outside WAIT SHALL be ignored.
REQ-013 Extraction little-endian: byte lane = m_alu[1:0] (00 -> bits 7:0); half lane = m_alu[1] (0 -> bits 15:0); LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-014 Misaligned LH/LHU (addr[0]=1) or LW (addr[1:0]!=0) SHALL skip WAIT, go to WRITE with writeReg=0 and adel=1 for that one cycle.
REQ-015 WRITE lasts exactly one cycle; writeReg = captured m_regWrite & (wa!=0) & ~adel; wa/wd held valid for the whole cycle (regfile samples on negedge).
REQ-016 From WRITE: accept -> WRITE (non-load) or WAIT (load), else IDLE; back-to-back non-loads SHALL give one write per cycle.
REQ-017 Latency: non-load accepted at edge N -> writeReg high in cycle N+1; load data at edge K (dm_rvalid) -> writeReg high in cycle K+1.
REQ-018 flush in WAIT SHALL return to IDLE with no write; dm_rvalid coincident with flush SHALL be discarded; flush in WRITE or IDLE SHALL not cancel the WRITE.
REQ-019 Outside WRITE, writeReg=0 and adel=0; wa/wd SHALL be 0 when writeReg=0.

Reset
REQ-020 rst SHALL force IDLE, m_ready=1 next cycle, writeReg=0, wa=0, wd=0, adel=0, ld_pending=0, ld_wa=0.
REQ-021 rst during WAIT SHALL abandon the load; a later dm_rvalid SHALL cause no write.
REQ-022 rst SHALL take priority over flush, accept and dm_rvalid.

Structure
REQ-023 mips_pkg SHALL hold the m_ldType encodings and the FSM state enum.
REQ-024 Extraction/extension SHALL be a combinational sub-module load_align (inputs ldType, addr[1:0], rdata; outputs data, misaligned).
REQ-025 All outputs SHALL be registered; m_ready SHALL be combinational from state and flush only.

Verification
REQ-026 ADD: accept m_wa=5, m_alu=0x0000_1234, ldType=000 -> next cycle writeReg=1, wa=5, wd=0x0000_1234; following cycle writeReg=0.
REQ-027 LB: m_alu=0x101, dm_rdata=0x1122_80FF after 3-cycle wait -> ld_pending=1 for 3 cycles, then wd=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-028 LW m_alu=0x102 -> no WAIT, adel=1 one cycle, writeReg=0; later dm_rvalid ignored.
REQ-029 m_wa=0, m_regWrite=1, m_alu=0xDEAD_BEEF -> writeReg=0 in WRITE cycle.
REQ-030 LH pending, flush and dm_rvalid same cycle -> IDLE, no write, m_ready=1 next cycle; rst mid-WAIT -> all outputs 0.
REQ-031 Three back-to-back non-loads (wa 1,2,3) -> writeReg high three consecutive cycles with wa 1,2,3 in order.
